// File: rtl/mem_access.sv
// Memory-access pipeline stage: load/store handshake with data memory, big-endian lane steering, writeback.
// Optional watchdog on the memory handshake is enabled by defining MEM_TIMEOUT_EN.
module mem_access #(
   parameter int unsigned XLEN           = 32,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            valid_in,
   input  logic [11:0]     operation,
   input  logic [XLEN-1:0] exec_out,
   input  logic [XLEN-1:0] content_rs2,
   input  logic [4:0]      address_rd,
   output logic            stall,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   output logic [3:0]      mem_be,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            mem_ack,
   output logic [XLEN-1:0] mem_data_out,
   output logic [XLEN-1:0] wb_value,
   output logic [4:0]      wb_rd,
   output logic            wb_valid,
   output logic            misaligned,
   output logic            bus_error
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   logic [1:0]      state;
   logic [2:0]      funct3;
   logic [1:0]      off;
   logic            is_load, is_store, is_mem, aligned, accept;
   logic [3:0]      be_next;
   logic [XLEN-1:0] wdata_next;
   logic [XLEN-1:0] load_shifted;
   logic            lat_load;
   logic [4:0]      lat_rd;
   logic [1:0]      lat_off;
   logic            unused_bits;

   assign funct3   = operation[9:7];
   assign off      = exec_out[1:0];
   assign is_load  = (operation[6:0] == OP_LOAD);
   assign is_store = (operation[6:0] == OP_STORE);
   assign is_mem   = is_load | is_store;

   always_comb begin
      aligned = 1'b1;
      case (funct3[1:0])
         2'b00:   aligned = 1'b1;
         2'b01:   aligned = ~off[0];
         default: aligned = (off == 2'b00);
      endcase
   end

   assign accept = (state == S_IDLE) && valid_in && is_mem && aligned;
   assign stall  = accept || (state == S_ACCESS);

   // Store data is replicated across all lanes; byte enables pick the addressed lanes.
   always_comb begin
      be_next    = 4'b1111;
      wdata_next = content_rs2;
      case (funct3[1:0])
         2'b00: begin
            be_next    = 4'b1000 >> off;
            wdata_next = {4{content_rs2[7:0]}};
         end
         2'b01: begin
            be_next    = 4'b1100 >> off;
            wdata_next = {2{content_rs2[15:0]}};
         end
         default: begin
            be_next    = 4'b1111;
            wdata_next = content_rs2;
         end
      endcase
      if (is_load) be_next = 4'b1111;
   end

   assign load_shifted = mem_rdata << {lat_off, 3'b000};

`ifdef MEM_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [TW-1:0] tcnt;
   assign unused_bits = ^operation[11:9];
`else
   assign unused_bits = ^{operation[11:9], TIMEOUT_CYCLES[0]};
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_be       <= '0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         mem_data_out <= '0;
         wb_value     <= '0;
         wb_rd        <= '0;
         wb_valid     <= 1'b0;
         misaligned   <= 1'b0;
         bus_error    <= 1'b0;
         lat_load     <= 1'b0;
         lat_rd       <= '0;
         lat_off      <= '0;
`ifdef MEM_TIMEOUT_EN
         tcnt         <= '0;
`endif
      end else begin
         wb_valid   <= 1'b0;
         misaligned <= 1'b0;
         bus_error  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (valid_in) begin
                  if (!is_mem) begin
                     wb_valid <= 1'b1;
                     wb_value <= exec_out;
                     wb_rd    <= address_rd;
                  end else if (!aligned) begin
                     misaligned <= 1'b1;
                  end else begin
                     state     <= S_ACCESS;
                     mem_req   <= 1'b1;
                     mem_we    <= is_store;
                     mem_addr  <= {exec_out[XLEN-1:2], 2'b00};
                     mem_be    <= be_next;
                     mem_wdata <= wdata_next;
                     lat_load  <= is_load;
                     lat_rd    <= address_rd;
                     lat_off   <= off;
`ifdef MEM_TIMEOUT_EN
                     tcnt      <= '0;
`endif
                  end
               end
            end
            S_ACCESS: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  state   <= S_RESP;
                  if (lat_load) begin
                     mem_data_out <= load_shifted;
                     wb_valid     <= 1'b1;
                     wb_value     <= load_shifted;
                     wb_rd        <= lat_rd;
                  end
               end
`ifdef MEM_TIMEOUT_EN
               else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                  mem_req   <= 1'b0;
                  bus_error <= 1'b1;
                  state     <= S_IDLE;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
`endif
            end
            S_RESP:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Randomized scoreboard bench for mem_access; a monitor checks requests and writebacks against queued expectations.
module tb_mem_access;
   localparam int unsigned TO = 4;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_in;
   logic [11:0] operation;
   logic [31:0] exec_out, content_rs2, mem_rdata;
   logic [4:0]  address_rd;
   logic        stall, mem_req, mem_we, mem_ack, wb_valid, misaligned, bus_error;
   logic [31:0] mem_addr, mem_wdata, mem_data_out, wb_value;
   logic [3:0]  mem_be;
   logic [4:0]  wb_rd;

   always #5 clk = ~clk;

   mem_access #(.XLEN(32), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .operation(operation),
      .exec_out(exec_out), .content_rs2(content_rs2), .address_rd(address_rd),
      .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .mem_data_out(mem_data_out), .wb_value(wb_value), .wb_rd(wb_rd),
      .wb_valid(wb_valid), .misaligned(misaligned), .bus_error(bus_error)
   );

   int errors = 0;
   int checks = 0;

   typedef struct { logic [31:0] val; logic [4:0] rd; bit ld; } wb_t;
   typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } req_t;
   wb_t  wbq[$];
   req_t reqq[$];
   wb_t  me;
   req_t mr;
   logic prev_req = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference model: byte lanes by plain arithmetic, lane b covers bits [31-8b -: 8].
   function automatic logic [3:0] model_be(input bit st, input int unsigned size, input int unsigned k);
      logic [3:0] be = '0;
      if (!st) return 4'hF;
      for (int unsigned b = 0; b < 4; b++)
         if (b >= k && b < k + size) be[3-b] = 1'b1;
      return be;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [31:0] rs2, input int unsigned size);
      logic [31:0] w = '0;
      for (int unsigned b = 0; b < 4; b++)
         w[31-8*b -: 8] = 8'((rs2 >> (8 * (size - 1 - (b % size)))) & 32'hFF);
      return w;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] rd, input int unsigned k);
      logic [31:0] r = '0;
      for (int unsigned j = 0; j < 4; j++)
         if (j + k < 4) r[31-8*j -: 8] = rd[31-8*(j+k) -: 8];
      return r;
   endfunction

   always @(negedge clk) begin
      if (wb_valid) begin
         if (wbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL wb_unexpected: got wb_valid=1 rd=%0d value=%h, expected no writeback", wb_rd, wb_value);
         end else begin
            me = wbq.pop_front();
            check("wb_value", wb_value, me.val);
            check("wb_rd", 32'(wb_rd), 32'(me.rd));
            if (me.ld) check("mem_data_out", mem_data_out, me.val);
         end
      end
      if (mem_req && !prev_req) begin
         if (reqq.size() == 0) begin
            checks++; errors++;
            $display("FAIL req_unexpected: got mem_req=1 addr=%h, expected no request", mem_addr);
         end else begin
            mr = reqq.pop_front();
            check("mem_addr", mem_addr, mr.addr);
            check("mem_we", 32'(mem_we), 32'(mr.we));
            check("mem_be", 32'(mem_be), 32'(mr.be));
            if (mr.we) check("mem_wdata", mem_wdata, mr.wdata);
         end
      end
      prev_req = mem_req;
   end

   // kind: 0 pass-through, 1 load, 2 store; mode: 0 normal, 1 reset mid-access, 2 no ack (timeout)
   task automatic do_op(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] rs2, input logic [4:0] rd, input logic [31:0] rdata,
                        input int unsigned delay, input int mode);
      int unsigned size, k;
      bit mem, al;
      logic [6:0] opc;
      logic [6:0] pt_ops [5] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b1100011, 7'b1101111};
      k    = 32'(addr[1:0]);
      size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      mem  = (kind != 0);
      al   = ((k % size) == 0);
      opc  = (kind == 1) ? OP_LOAD : (kind == 2) ? OP_STORE : pt_ops[$urandom_range(4)];

      @(negedge clk);
      valid_in    = 1'b1;
      operation   = {2'($urandom), f3, opc};
      exec_out    = addr;
      content_rs2 = rs2;
      address_rd  = rd;
      mem_ack     = 1'($urandom);
      mem_rdata   = $urandom;
      if (!mem) wbq.push_back('{val: addr, rd: rd, ld: 1'b0});
      else if (al) begin
         reqq.push_back('{addr: addr & 32'hFFFF_FFFC, we: (kind == 2),
                          be: model_be(kind == 2, size, k), wdata: model_wdata(rs2, size)});
         if (kind == 1 && mode == 0) wbq.push_back('{val: model_load(rdata, k), rd: rd, ld: 1'b1});
      end
      #1 check("stall_issue", 32'(stall), 32'(mem && al));

      @(negedge clk);
      valid_in    = 1'b0;
      exec_out    = $urandom;
      content_rs2 = $urandom;
      #1 check("misaligned", 32'(misaligned), 32'(mem && !al));
      check("bus_error_idle", 32'(bus_error), 32'd0);
      if (!mem || !al) begin
         check("mem_req_idle", 32'(mem_req), 32'd0);
         return;
      end

      if (mode == 1) begin
         mem_ack = 1'b0;
         reset   = 1'b1;
         @(negedge clk);
         reset = 1'b0;
         #1 check("abort_mem_req", 32'(mem_req), 32'd0);
         check("abort_stall", 32'(stall), 32'd0);
         check("abort_mem_be", 32'(mem_be), 32'd0);
         check("abort_mem_addr", mem_addr, 32'd0);
         return;
      end

      if (mode == 2) begin
         for (int unsigned d = 0; d < TO; d++) begin
            if (d > 0) @(negedge clk);
            mem_ack = 1'b0;
            #1 check("to_mem_req", 32'(mem_req), 32'd1);
         end
         @(negedge clk);
         #1 check("to_mem_req_drop", 32'(mem_req), 32'd0);
         check("to_bus_error", 32'(bus_error), 32'd1);
         check("to_stall", 32'(stall), 32'd0);
         @(negedge clk);
         #1 check("to_bus_error_pulse", 32'(bus_error), 32'd0);
         return;
      end

      for (int unsigned d = 0; d <= delay; d++) begin
         if (d > 0) @(negedge clk);
         mem_ack   = (d == delay);
         mem_rdata = (d == delay) ? rdata : $urandom;
         #1 check("mem_req_access", 32'(mem_req), 32'd1);
         check("stall_access", 32'(stall), 32'd1);
      end
      @(negedge clk);
      mem_ack   = 1'($urandom);
      mem_rdata = $urandom;
      #1 check("mem_req_resp", 32'(mem_req), 32'd0);
      check("stall_resp", 32'(stall), 32'd0);
   endtask

   initial begin
      logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      logic [2:0] st_f3 [3] = '{3'b000, 3'b001, 3'b010};
      int kind;
      reset = 1'b1; valid_in = 1'b0; operation = '0; exec_out = '0;
      content_rs2 = '0; address_rd = '0; mem_rdata = '0; mem_ack = 1'b0;
      repeat (3) @(negedge clk);
      #1 check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_be", 32'(mem_be), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_mem_data_out", mem_data_out, 32'd0);
      check("rst_wb", {wb_value[26:0], wb_rd}, 32'd0);
      check("rst_flags", {29'd0, wb_valid, misaligned, bus_error}, 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      reset = 1'b0;

      do_op(0, 3'b000, 32'h0000_0005, 32'h0, 5'd3, 32'h0, 0, 0);
      do_op(1, 3'b000, 32'h0000_1002, 32'h0, 5'd7, 32'h1122_3344, 1, 0);
      do_op(1, 3'b000, 32'h0000_1003, 32'h0, 5'd8, 32'h1122_3344, 0, 0);
      do_op(2, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 5'd9, 32'h0, 0, 0);
      do_op(1, 3'b010, 32'h0000_3001, 32'h0, 5'd4, 32'h0, 0, 0);
      do_op(1, 3'b001, 32'h0000_3003, 32'h0, 5'd4, 32'h0, 0, 0);
      do_op(2, 3'b010, 32'h0000_4000, 32'hCAFE_F00D, 5'd0, 32'h0, 2, 1);
      do_op(1, 3'b010, 32'h0000_0100, 32'h0, 5'd0, 32'hA5A5_5A5A, 0, 0);
      do_op(2, 3'b000, 32'h0000_0101, 32'h1234_5678, 5'd1, 32'h0, 3, 0);

      for (int i = 0; i < 300; i++) begin
         kind = $urandom_range(2);
         do_op(kind,
               (kind == 1) ? ld_f3[$urandom_range(4)] : (kind == 2) ? st_f3[$urandom_range(2)] : 3'($urandom),
               $urandom, $urandom, 5'($urandom), $urandom, $urandom_range(3), 0);
      end

`ifdef MEM_TIMEOUT_EN
      do_op(1, 3'b010, 32'h0000_5000, 32'h0, 5'd5, 32'h0, 0, 2);
      do_op(1, 3'b010, 32'h0000_5004, 32'h0, 5'd6, 32'h7777_8888, 1, 0);
`endif

      repeat (3) @(negedge clk);
      check("wbq_drained", 32'(wbq.size()), 32'd0);
      check("reqq_drained", 32'(reqq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
